// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencer and its consumers.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    PC_RUN    = 2'b00,
    PC_DRAIN  = 2'b01,
    PC_HALTED = 2'b10
  } pc_state_t;

  // Bit positions inside stage_en: bit 0 loads the PC, bit k loads s(k+1).
  localparam int STG_PC = 0;
  localparam int STG_S2 = 1;
  localparam int STG_S3 = 2;
  localparam int STG_S4 = 3;
  localparam int STG_S5 = 4;
  localparam int STG_S6 = 5;

  // Instruction word the s2 register loads when bubble_s2 is asserted.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the core datapath and the pipeline sequencer.
interface pipe_ctrl_if #(
  parameter int N_STAGES = 6,
  parameter int CNT_BITS = 16
);

  logic                stall_pipe;
  logic                redirect;
  logic                imem_wait;
  logic                dmem_wait;
  logic                halt_req;
  logic                clr_stats;
  logic [N_STAGES-1:0] stage_en;
  logic                bubble_s2;
  logic                bubble_s3;
  logic                halted;
  logic                hang_err;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] flush_cnt;

  // Core side: raises requests, consumes enables and status.
  modport master (
    output stall_pipe, redirect, imem_wait, dmem_wait, halt_req, clr_stats,
    input  stage_en, bubble_s2, bubble_s3, halted, hang_err, stall_cnt, flush_cnt
  );

  // Sequencer side.
  modport slave (
    input  stall_pipe, redirect, imem_wait, dmem_wait, halt_req, clr_stats,
    output stage_en, bubble_s2, bubble_s3, halted, hang_err, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
  parameter int             W   = 16,
  parameter logic [W-1:0]   MAX = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  // Count up to MAX and hold there until cleared.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != MAX)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stage enables, bubbles, halt/drain FSM, watchdog, statistics.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int N_STAGES = 6,
  parameter int CNT_BITS = 16,
  parameter int WDOG_MAX = 1024
) (
  input  logic     clk,
  input  logic     rst,
  pipe_ctrl_if.slave bus
);

  localparam int DW = $clog2(N_STAGES);
  localparam int WW = $clog2(WDOG_MAX + 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(N_STAGES - 1);
  localparam logic [WW-1:0] WDOG_LIM   = WW'(WDOG_MAX);

  pc_state_t           state;
  logic [DW-1:0]       drain_cnt;
  logic                halted_q;
  logic                hang_q;
  logic [N_STAGES-1:0] en;
  logic                b2;
  logic                b3;
  logic                stall_acc;
  logic                flush_acc;
  logic                active;
  logic                stats_clr;
  logic                wdog_inc;
  logic                wdog_hit;
  logic [WW-1:0]       wdog_cnt;
  logic [CNT_BITS-1:0] stall_q;
  logic [CNT_BITS-1:0] flush_q;

  assign active    = !rst && (state != PC_HALTED);
  assign stats_clr = bus.clr_stats && (state != PC_HALTED);

  // Enable/bubble decode; first matching request wins, drain adds its overrides.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    en        = '0;
    b2        = 1'b0;
    b3        = 1'b0;
    stall_acc = 1'b0;
    flush_acc = 1'b0;
    if (active) begin
      if (bus.dmem_wait) begin
        en = '0;
      end else if (bus.stall_pipe) begin
        // A redirect under a hazard stall is dropped: the branch re-presents from s2.
        en         = '1;
        en[STG_PC] = 1'b0;
        en[STG_S2] = 1'b0;
        b3         = 1'b1;
        stall_acc  = 1'b1;
      end else if (bus.redirect) begin
        en        = '1;
        b2        = 1'b1;
        flush_acc = 1'b1;
      end else if (bus.imem_wait) begin
        en         = '1;
        en[STG_PC] = 1'b0;
        b2         = 1'b1;
      end else begin
        en = '1;
      end
      if (state == PC_DRAIN) begin
        // Stop fetching; the PC only moves to capture a resume target.
        b2 = 1'b1;
        if (!flush_acc) en[STG_PC] = 1'b0;
      end
    end
  end

  // Halt/drain FSM with registered halted and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PC_RUN;
      drain_cnt <= '0;
      halted_q  <= 1'b0;
      hang_q    <= 1'b0;
    end else begin
      case (state)
        PC_RUN: begin
          if (bus.halt_req) begin
            state     <= PC_DRAIN;
            drain_cnt <= DRAIN_LOAD;
          end
        end
        PC_DRAIN: begin
          if (!bus.dmem_wait && !bus.stall_pipe) begin
            drain_cnt <= drain_cnt - 1'b1;
            if (drain_cnt == DW'(1)) begin
              state    <= PC_HALTED;
              halted_q <= 1'b1;
            end
          end
        end
        PC_HALTED: begin
          if (!bus.halt_req) begin
            state    <= PC_RUN;
            halted_q <= 1'b0;
          end
        end
        default: state <= PC_RUN;
      endcase
      if (wdog_hit) hang_q <= 1'b1;
    end
  end

  // Watchdog counts consecutive cycles with s2 frozen; flag rises as it reaches the limit.
  assign wdog_inc = active && !en[STG_S2];
  assign wdog_hit = wdog_inc && (wdog_cnt >= (WDOG_LIM - 1'b1));

  sat_counter #(.W(WW), .MAX(WDOG_LIM)) u_wdog (
    .clk (clk),
    .rst (rst),
    .inc (wdog_inc),
    .clr (!wdog_inc),
    .q   (wdog_cnt)
  );

  sat_counter #(.W(CNT_BITS)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_acc),
    .clr (stats_clr),
    .q   (stall_q)
  );

  sat_counter #(.W(CNT_BITS)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_acc),
    .clr (stats_clr),
    .q   (flush_q)
  );

  assign bus.stage_en  = en;
  assign bus.bubble_s2 = b2;
  assign bus.bubble_s3 = b3;
  assign bus.halted    = halted_q;
  assign bus.hang_err  = hang_q;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

endmodule
